// File: rtl/memory_unit.sv
// Memory stage: registers the instruction leaving execute, forwards its ALU
// result, runs the data-memory handshake for LDR/STR and registers writeback.
//
// Memory handshake: mem_req is raised only in ACCESS and, together with
// mem_addr/mem_we/mem_wdata, holds steady until the memory answers with a
// one-cycle mem_ack (mem_rdata valid in that cycle) or the timeout expires.
// mem_ack is ignored whenever mem_req is low.
module memory_unit #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] BUBBLE  = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        sel_stall,
    output logic [3:0]  rd,
    output logic        rd_valid,
    output logic [31:0] fwd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err,
    output logic [1:0]  dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   instr_q, alu_q, sdata_q, ld_q;
    logic [CW-1:0] counter;

    logic valid, dp, mem, load, store, cmp_type, writes, adv;
    logic unused_instr_bits;

    // Decode of the instruction held in the stage
    assign valid    = instr_q[31:28] != 4'b1111;
    assign dp       = instr_q[27:26] == 2'b00;
    assign mem      = instr_q[27:26] == 2'b01;
    assign load     = mem && instr_q[20];
    assign store    = mem && !instr_q[20];
    assign cmp_type = dp && (instr_q[24:23] == 2'b10);
    assign writes   = valid && ((dp && !cmp_type) || load);
    assign adv      = !sel_stall;

    assign unused_instr_bits = ^{instr_q[25], instr_q[22:21], instr_q[19:16], instr_q[11:0]};

    // Forwarding source: loads have no data yet, so they never forward
    assign rd        = instr_q[15:12];
    assign rd_valid  = writes && !load;
    assign fwd_data  = alu_q;
    assign dbg_state = state;

    // Stage registers: capture from execute whenever the stage advances
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= BUBBLE;
            alu_q   <= '0;
            sdata_q <= '0;
        end else if (adv) begin
            instr_q <= flush ? BUBBLE : instr_in;
            alu_q   <= alu_result;
            sdata_q <= store_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next-state: DONE/ERR return to IDLE on the same edge a new instr enters
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (valid && mem) state_nx = S_ACCESS;
            S_ACCESS: begin
                if (mem_ack)              state_nx = S_DONE;
                else if (counter == LAST) state_nx = S_ERR;
            end
            S_DONE:   state_nx = S_IDLE;
            S_ERR:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: request bus driven only in ACCESS, stall until access resolves
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = store;
            mem_addr  = alu_q;
            mem_wdata = sdata_q;
        end
        sel_stall = valid && mem && (state == S_IDLE || state == S_ACCESS);
    end

    // Access datapath: wait counter, load data capture, sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            ld_q    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (valid && mem) counter <= '0;
                S_ACCESS: begin
                    if (mem_ack) begin
                        ld_q <= mem_rdata;
                    end else if (counter == LAST) begin
                        mem_err <= 1'b1;
                        ld_q    <= '0;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Writeback: the instruction leaving the stage writes the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (adv) begin
            wb_en   <= writes && !(load && state == S_ERR);
            wb_rd   <= instr_q[15:12];
            wb_data <= load ? ld_q : alu_q;
        end else begin
            wb_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: a transaction-level model of the stage predicts
// every output each cycle; a memory responder answers requests with a
// per-instruction latency (0 = never answer, forcing a timeout).
module tb_memory_unit;

    localparam int          TIMEOUT = 4;
    localparam logic [31:0] BUBBLE  = 32'hF000_0000;

    logic        clk, rst;
    logic [31:0] instr_in, alu_result, store_data;
    logic        flush;
    logic        sel_stall;
    logic [3:0]  rd;
    logic        rd_valid;
    logic [31:0] fwd_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;
    logic [1:0]  dbg_state;

    memory_unit #(.TIMEOUT(TIMEOUT), .BUBBLE(BUBBLE)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .alu_result(alu_result),
        .store_data(store_data), .flush(flush), .sel_stall(sel_stall),
        .rd(rd), .rd_valid(rd_valid), .fwd_data(fwd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    bit done         = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction classification ----------------
    function automatic bit f_valid(input logic [31:0] i);
        return i[31:28] != 4'hF;
    endfunction
    function automatic bit f_load(input logic [31:0] i);
        return (i[27:26] == 2'b01) && i[20];
    endfunction
    function automatic bit f_store(input logic [31:0] i);
        return (i[27:26] == 2'b01) && !i[20];
    endfunction
    function automatic bit f_mem_valid(input logic [31:0] i);
        return f_valid(i) && (i[27:26] == 2'b01);
    endfunction
    function automatic bit f_writes(input logic [31:0] i);
        int op;
        bit dp, cmp;
        op  = int'(i[24:21]);
        dp  = i[27:26] == 2'b00;
        cmp = dp && (op >= 8) && (op <= 11);
        return f_valid(i) && ((dp && !cmp) || f_load(i));
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_instr, m_alu, m_sd, m_ld;
    logic [31:0] m_mem [16];
    logic [31:0] ram   [16];
    int          m_left, m_n, m_lat;
    bit          m_to;
    bit          exp_err, exp_wb_en;
    logic [3:0]  exp_wb_rd;
    logic [31:0] exp_wb_data;
    int          acc_cnt;
    int          next_lat;
    int          cfg_q[$];

    // Stage occupancy model: a memory instruction holds the stage for one
    // decode cycle, N request cycles and one completion cycle.
    initial begin
        m_instr = BUBBLE; m_alu = 0; m_sd = 0; m_ld = 0;
        m_left = 0; m_n = 0; m_to = 0; exp_err = 0; exp_wb_en = 0;
        exp_wb_rd = 0; exp_wb_data = 0; acc_cnt = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_instr = BUBBLE; m_alu = 0; m_sd = 0;
                m_left = 0; m_n = 0; m_to = 0;
                exp_err = 0; exp_wb_en = 0; exp_wb_rd = 0; exp_wb_data = 0;
                cfg_q.delete();
            end else if (m_left > 0) begin
                m_left--;
                exp_wb_en = 0;
                if (m_left == 0 && m_to) exp_err = 1;
            end else begin
                exp_wb_en   = f_writes(m_instr) && !(f_load(m_instr) && m_to);
                exp_wb_rd   = m_instr[15:12];
                exp_wb_data = f_load(m_instr) ? m_ld : m_alu;
                m_instr = flush ? BUBBLE : instr_in;
                m_alu   = alu_result;
                m_sd    = store_data;
                m_to    = 0;
                m_n     = 0;
                if (f_mem_valid(m_instr)) begin
                    m_lat  = next_lat;
                    m_to   = (m_lat == 0);
                    m_n    = m_to ? TIMEOUT : m_lat;
                    m_left = 1 + m_n;
                    cfg_q.push_back(m_lat);
                    if (f_load(m_instr)) m_ld = m_to ? 32'h0 : m_mem[m_alu[5:2]];
                    else if (!m_to)      m_mem[m_alu[5:2]] = m_sd;
                end
                acc_cnt++;
            end
        end
    end

    // ---------------- memory responder ----------------
    int req_cycles = 0;
    int cur_lat    = 0;
    bit noise_en   = 0;

    initial begin
        mem_ack = 0; mem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (req_cycles == 0) cur_lat = (cfg_q.size() > 0) ? cfg_q.pop_front() : 0;
                req_cycles++;
                mem_ack = (cur_lat != 0) && (req_cycles == cur_lat);
                if (mem_ack) begin
                    mem_rdata = ram[mem_addr[5:2]];
                    if (mem_we) ram[mem_addr[5:2]] = mem_wdata;
                end else begin
                    mem_rdata = $urandom;
                end
            end else begin
                req_cycles = 0;
                mem_ack    = noise_en && ($urandom_range(0, 2) == 0);
                mem_rdata  = $urandom;
            end
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    initial begin
        bit exp_req;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_req = (m_left >= 1) && (m_left <= m_n);
                check("sel_stall", sel_stall, m_left > 0);
                check("rd", rd, m_instr[15:12]);
                check("rd_valid", rd_valid, f_writes(m_instr) && !f_load(m_instr));
                check("fwd_data", fwd_data, m_alu);
                check("mem_req", mem_req, exp_req);
                if (exp_req) begin
                    check("mem_addr", mem_addr, m_alu);
                    check("mem_we", mem_we, f_store(m_instr));
                    check("mem_wdata", mem_wdata, m_sd);
                end
                check("wb_en", wb_en, exp_wb_en);
                if (exp_wb_en) begin
                    check("wb_rd", wb_rd, exp_wb_rd);
                    check("wb_data", wb_data, exp_wb_data);
                end
                check("mem_err", mem_err, exp_err);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] s,
                        input bit f, input int lat);
        int start;
        start      = acc_cnt;
        instr_in   = i;
        alu_result = a;
        store_data = s;
        flush      = f;
        next_lat   = lat;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) break;
        end
    endtask

    task automatic go_idle(input int n);
        instr_in = BUBBLE;
        flush    = 0;
        next_lat = 1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0]  cond;
        logic [3:0]  op;
        r    = $urandom;
        cond = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        op   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(12, 15));
        case ($urandom_range(0, 5))
            0, 1:    return {cond, 2'b00, r[25], op, r[20:0]};
            2:       return {cond, 2'b00, r[25], 4'($urandom_range(8, 11)), r[20:0]};
            3:       return {cond, 2'b01, r[25:21], 1'b1, r[19:0]};
            4:       return {cond, 2'b01, r[25:21], 1'b0, r[19:0]};
            default: return {cond, 1'b1, r[26:0]};
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        if (!done) begin
            check("watchdog", done, 1);
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        int          lat;
        rst = 1; instr_in = BUBBLE; alu_result = 0; store_data = 0; flush = 0; next_lat = 1;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            ram[i]   = v;
            m_mem[i] = v;
        end
        ram[0]   = 32'h0000_CAFE;
        m_mem[0] = 32'h0000_CAFE;

        // reset for two cycles, then every output must be zero
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        @(negedge clk);
        check("rst_sel_stall", sel_stall, 0);
        check("rst_rd", rd, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_fwd", fwd_data, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_state", dbg_state, 0);

        // ALU op then compare
        send(32'hE082_1003, 32'h5, 32'h0, 0, 1);
        send(32'hE150_0001, 32'h7, 32'h0, 0, 1);
        go_idle(2);

        // load, ack on second request cycle
        send(32'hE590_4000, 32'h100, 32'h0, 0, 2);
        go_idle(1);
        // store, immediate ack
        send(32'hE580_4000, 32'h200, 32'h1234, 0, 1);
        go_idle(1);
        // load acked on the last allowed cycle
        send(32'hE590_9008, 32'h8, 32'h0, 0, TIMEOUT);
        go_idle(1);
        // load with no answer: timeout
        send(32'hE590_A00C, 32'h300, 32'h0, 0, 0);
        go_idle(3);
        // flushed ALU op
        send(32'hE082_1003, 32'h77, 32'h0, 1, 1);
        go_idle(2);
        // back-to-back loads
        send(32'hE590_5000, 32'h104, 32'h0, 0, 1);
        send(32'hE590_6004, 32'h108, 32'h0, 0, 3);
        go_idle(4);

        // reset while a request is outstanding
        send(32'hE590_7000, 32'h10C, 32'h0, 0, 0);
        instr_in = BUBBLE;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_req", mem_req, 0);
        check("post_rst_state", dbg_state, 0);
        check("post_rst_err", mem_err, 0);
        @(posedge clk); #1;

        // randomized traffic with stray acks between requests
        noise_en = 1;
        for (int n = 0; n < 300; n++) begin
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            send(rand_instr(), $urandom, $urandom, $urandom_range(0, 7) == 0, lat);
        end
        noise_en = 0;
        go_idle(12);

        check("cfg_drained", cfg_q.size(), 0);
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
